// File: rtl/cmos_sync_tx.sv
// CMOS sensor stand-in: emits SAV/EAV-framed lines (FF 00 00 XY) with a
// deterministic pixel ramp on valid lines, one byte per clock.
module cmos_sync_tx #(
    parameter int unsigned H_ACTIVE   = 64,
    parameter int unsigned H_BLANK    = 16,
    parameter int unsigned V_PRE      = 8,
    parameter int unsigned V_ACTIVE   = 32,
    parameter int unsigned V_POST     = 4,
    parameter logic [7:0]  BLANK_BYTE = 8'h10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] bayer,
    output logic       sof,
    output logic       eof,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, SAV, PAYLOAD, EAV, HBLANK} state_t;

    localparam logic [13:0] PAY_LAST    = 14'(H_ACTIVE - 1);
    localparam logic [13:0] BLANK_LAST  = 14'(H_BLANK - 1);
    localparam logic [11:0] LINE_LAST   = 12'(V_PRE + V_ACTIVE + V_POST - 1);
    localparam logic [11:0] VALID_FIRST = 12'(V_PRE);
    localparam logic [11:0] VALID_END   = 12'(V_PRE + V_ACTIVE);

    state_t      state_q, state_d;
    logic [13:0] colCnt_q, colCnt_d;
    logic [11:0] lineCnt_q, lineCnt_d;
    logic [7:0]  frameCnt_q, frameCnt_d;
    logic [7:0]  frameBase_q, frameBase_d;
    logic [7:0]  lineStart_q, lineStart_d;
    logic [7:0]  pix_q, pix_d;
    logic [7:0]  bayer_q, bayer_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        busy_q, busy_d;

    logic        validLine;
    logic [7:0]  nextBase;
    logic [7:0]  codeByte;

    // Pixel values live in 0x01..0xFE so the payload can never mimic a sync code.
    function automatic logic [7:0] pixInc(input logic [7:0] v);
        return (v == 8'hFE) ? 8'h01 : v + 8'h01;
    endfunction

    assign validLine = (lineCnt_q >= VALID_FIRST) && (lineCnt_q < VALID_END);
    // frameBase tracks (frame_cnt mod 254) + 1; an 8-bit wrap lands back on 1.
    assign nextBase  = (frameCnt_q == 8'hFF) ? 8'h01 : pixInc(frameBase_q);

    always_comb begin
        codeByte = 8'h00;
        case (colCnt_q[1:0])
            2'd0:    codeByte = 8'hFF;
            2'd3: begin
                if (state_q == SAV) codeByte = validLine ? 8'h80 : 8'hAB;
                else                codeByte = validLine ? 8'h9D : 8'hB6;
            end
            default: codeByte = 8'h00;
        endcase
    end

    // Outputs are registered one cycle behind the state that produced them.
    always_comb begin
        state_d     = state_q;
        colCnt_d    = colCnt_q;
        lineCnt_d   = lineCnt_q;
        frameCnt_d  = frameCnt_q;
        frameBase_d = frameBase_q;
        lineStart_d = lineStart_q;
        pix_d       = pix_q;
        bayer_d     = BLANK_BYTE;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        busy_d      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = SAV;
                    colCnt_d  = 14'd0;
                    lineCnt_d = 12'd0;
                end
            end
            SAV: begin
                bayer_d = codeByte;
                sof_d   = (colCnt_q == 14'd0) && (lineCnt_q == 12'd0);
                if (colCnt_q == 14'd3) begin
                    state_d  = PAYLOAD;
                    colCnt_d = 14'd0;
                    pix_d    = lineStart_q;
                end else begin
                    colCnt_d = colCnt_q + 14'd1;
                end
            end
            PAYLOAD: begin
                bayer_d = validLine ? pix_q : BLANK_BYTE;
                pix_d   = pixInc(pix_q);
                if (colCnt_q == PAY_LAST) begin
                    state_d  = EAV;
                    colCnt_d = 14'd0;
                end else begin
                    colCnt_d = colCnt_q + 14'd1;
                end
            end
            EAV: begin
                bayer_d = codeByte;
                if (colCnt_q == 14'd3) begin
                    state_d  = HBLANK;
                    colCnt_d = 14'd0;
                end else begin
                    colCnt_d = colCnt_q + 14'd1;
                end
            end
            HBLANK: begin
                if (colCnt_q == BLANK_LAST) begin
                    colCnt_d = 14'd0;
                    if (validLine) lineStart_d = pixInc(lineStart_q);
                    if (lineCnt_q == LINE_LAST) begin
                        eof_d       = 1'b1;
                        frameCnt_d  = frameCnt_q + 8'd1;
                        frameBase_d = nextBase;
                        lineStart_d = nextBase;
                        lineCnt_d   = 12'd0;
                        state_d     = en ? SAV : IDLE;
                    end else begin
                        lineCnt_d = lineCnt_q + 12'd1;
                        state_d   = SAV;
                    end
                end else begin
                    colCnt_d = colCnt_q + 14'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            colCnt_q    <= 14'd0;
            lineCnt_q   <= 12'd0;
            frameCnt_q  <= 8'd0;
            frameBase_q <= 8'h01;
            lineStart_q <= 8'h01;
            pix_q       <= 8'h00;
            bayer_q     <= BLANK_BYTE;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            colCnt_q    <= colCnt_d;
            lineCnt_q   <= lineCnt_d;
            frameCnt_q  <= frameCnt_d;
            frameBase_q <= frameBase_d;
            lineStart_q <= lineStart_d;
            pix_q       <= pix_d;
            bayer_q     <= bayer_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
        end
    end

    assign bayer = bayer_q;
    assign sof   = sof_q;
    assign eof   = eof_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_cmos_sync_tx.sv
// Bench for cmos_sync_tx: a small-geometry instance for framing/timing and a
// wide-line instance for pixel wrap, both checked against a positional model.
module tb_cmos_sync_tx;

    localparam int HA = 8, HB = 4, VP = 6, VA = 4, VPO = 2;
    localparam int LINE  = HA + HB + 8;
    localparam int FRAME = LINE * (VP + VA + VPO);
    localparam int HA2 = 300, HB2 = 4, VP2 = 5, VA2 = 2, VPO2 = 0;
    localparam int LINE2  = HA2 + HB2 + 8;
    localparam int FRAME2 = LINE2 * (VP2 + VA2 + VPO2);

    logic       clk = 1'b0;
    logic       rst, en, en2;
    logic [7:0] bayer, bayer2;
    logic       sof, eof, busy, sof2, eof2, busy2;

    int vectors = 0;
    int miscompares = 0;

    cmos_sync_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_PRE(VP), .V_ACTIVE(VA),
                   .V_POST(VPO), .BLANK_BYTE(8'h10)) dut (
        .clk(clk), .rst(rst), .en(en), .bayer(bayer), .sof(sof), .eof(eof), .busy(busy));

    cmos_sync_tx #(.H_ACTIVE(HA2), .H_BLANK(HB2), .V_PRE(VP2), .V_ACTIVE(VA2),
                   .V_POST(VPO2), .BLANK_BYTE(8'h10)) dutWide (
        .clk(clk), .rst(rst), .en(en2), .bayer(bayer2), .sof(sof2), .eof(eof2), .busy(busy2));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected byte at a position within a frame, derived from the line layout.
    function automatic logic [7:0] modelByte(int pos, int fc, int ha, int hb, int vp, int va);
        int ll, ln, c, row, k;
        bit valid;
        ll    = ha + hb + 8;
        ln    = pos / ll;
        c     = pos % ll;
        row   = ln - vp;
        valid = (ln >= vp) && (ln < vp + va);
        if (c < 4 || (c >= ha + 4 && c < ha + 8)) begin
            k = (c < 4) ? c : c - ha - 4;
            if (k == 0) return 8'hFF;
            if (k < 3)  return 8'h00;
            if (c < 4)  return valid ? 8'h80 : 8'hAB;
            return valid ? 8'h9D : 8'hB6;
        end
        if (c < ha + 4) return valid ? 8'(((c - 4 + row + fc) % 254) + 1) : 8'h10;
        return 8'h10;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; en2 = 1'b0;
        step();
        step();
        vectors++;
        if ({bayer, sof, eof, busy} !== {8'h10, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL reset_state got %h/%b%b%b want 10/000", bayer, sof, eof, busy);
        end
        vectors++;
        if ({bayer2, busy2} !== {8'h10, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_wide got %h/%b want 10/0", bayer2, busy2);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            vectors++;
            if ({bayer, sof, busy} !== {8'h10, 2'b00}) begin
                miscompares++;
                $display("[TB] FAIL idle_cycle%0d got %h/%b%b want 10/00", i, bayer, sof, busy);
            end
        end
    endtask

    task automatic test_single_frame();
        int lat;
        en = 1'b1;
        step();
        en = 1'b0;
        lat = 1;
        while (sof !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        vectors++;
        if (lat != 2) begin
            miscompares++;
            $display("[TB] FAIL start_latency got %0d want 2", lat);
        end
        for (int p = 0; p < FRAME; p++) begin
            logic [7:0] exp;
            exp = modelByte(p, 0, HA, HB, VP, VA);
            vectors++;
            if ({bayer, sof, eof, busy} !== {exp, p == 0, p == FRAME - 1, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL frame0_pos%0d got %h/%b%b%b want %h/%b%b1",
                         p, bayer, sof, eof, busy, exp, p == 0, p == FRAME - 1);
            end
            step();
        end
        vectors++;
        if ({bayer, busy} !== {8'h10, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL frame0_idle got %h/%b want 10/0", bayer, busy);
        end
    endtask

    task automatic test_back_to_back();
        en = 1'b1;
        step();
        step();
        for (int p = 0; p < 3 * FRAME; p++) begin
            logic [7:0] exp;
            int fp;
            fp  = p % FRAME;
            exp = modelByte(fp, 1 + p / FRAME, HA, HB, VP, VA);
            vectors++;
            if ({bayer, sof, eof, busy} !== {exp, fp == 0, fp == FRAME - 1, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL b2b_pos%0d got %h/%b%b%b want %h/%b%b1",
                         p, bayer, sof, eof, busy, exp, fp == 0, fp == FRAME - 1);
            end
            if (p == 2 * FRAME + 10) en = 1'b0;
            step();
        end
        vectors++;
        if ({bayer, busy} !== {8'h10, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL b2b_idle got %h/%b want 10/0", bayer, busy);
        end
    endtask

    task automatic test_reset_midframe();
        en = 1'b1;
        step();
        en = 1'b0;
        step();
        for (int p = 0; p < 100; p++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({bayer, sof, eof, busy} !== {8'h10, 3'b000}) begin
            miscompares++;
            $display("[TB] FAIL midreset got %h/%b%b%b want 10/000", bayer, sof, eof, busy);
        end
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if ({bayer, busy} !== {8'h10, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL midreset_idle got %h/%b want 10/0", bayer, busy);
        end
        en = 1'b1;
        step();
        en = 1'b0;
        step();
        for (int p = 0; p < FRAME; p++) begin
            logic [7:0] exp;
            exp = modelByte(p, 0, HA, HB, VP, VA);
            vectors++;
            if ({bayer, sof, eof, busy} !== {exp, p == 0, p == FRAME - 1, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL restart_pos%0d got %h/%b%b%b want %h/%b%b1",
                         p, bayer, sof, eof, busy, exp, p == 0, p == FRAME - 1);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] prev1, prev2;
        bit seenWrap;
        int start;
        prev1 = 8'h10; prev2 = 8'h10; seenWrap = 1'b0;
        en2 = 1'b1;
        step();
        en2 = 1'b0;
        step();
        for (int p = 0; p < FRAME2; p++) begin
            logic [7:0] exp;
            exp = modelByte(p, 0, HA2, HB2, VP2, VA2);
            vectors++;
            if ({bayer2, sof2, eof2, busy2} !== {exp, p == 0, p == FRAME2 - 1, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL wide_pos%0d got %h/%b%b%b want %h/%b%b1",
                         p, bayer2, sof2, eof2, busy2, exp, p == 0, p == FRAME2 - 1);
            end
            if (prev2 == 8'hFF && prev1 == 8'h00 && bayer2 == 8'h00) begin
                start = (p - 2) % LINE2;
                vectors++;
                if (start != 0 && start != HA2 + 4) begin
                    miscompares++;
                    $display("[TB] FAIL sync_position got col %0d want 0 or %0d", start, HA2 + 4);
                end
            end
            if (prev1 == 8'hFE && bayer2 == 8'h01) seenWrap = 1'b1;
            prev2 = prev1;
            prev1 = bayer2;
            step();
        end
        vectors++;
        if (!seenWrap) begin
            miscompares++;
            $display("[TB] FAIL pixel_wrap got no FE->01 want FE->01");
        end
        vectors++;
        if ({bayer2, busy2} !== {8'h10, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wide_idle got %h/%b want 10/0", bayer2, busy2);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en2 = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_midframe();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
